// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives data memory over a req/ack handshake, builds byte enables and
// replicated store data, extends load data and stalls upstream while an access is in flight.
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [31:0] inALUResult,
  input  logic [31:0] inWriteData,
  input  logic [4:0]  inWriteReg,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inMemSize,
  input  logic        inMemUnsigned,
  input  logic        inMemToReg,
  input  logic        inRegWrite,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        outValid,
  output logic [31:0] outALUResult,
  output logic [31:0] outReadData,
  output logic [4:0]  outWriteReg,
  output logic        outMemToReg,
  output logic        outRegWrite,
  output logic        outMisalign,
  output logic        outMemErr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [3:0]  be_reg;
  logic [1:0]  size_reg;
  logic [4:0]  writereg_reg;
  logic        unsigned_reg, we_reg, memtoreg_reg, regwrite_reg, err_reg;

  logic        in_mem_op, in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign in_mem_op = inValid & (inMemRead | inMemWrite);

  always_comb begin
    in_misalign = 1'b0;
    in_be       = 4'b1111;
    in_wdata    = inWriteData;
    case (inMemSize)
      2'b00: begin
        in_be    = 4'b0001 << inALUResult[1:0];
        in_wdata = {4{inWriteData[7:0]}};
      end
      2'b01: begin
        in_misalign = inALUResult[0];
        in_be       = inALUResult[1] ? 4'b1100 : 4'b0011;
        in_wdata    = {2{inWriteData[15:0]}};
      end
      default: in_misalign = (inALUResult[1:0] != 2'b00);
    endcase
  end

  // Lane selection uses the latched address, since the inputs may change while BUSY
  assign byte_sel = 8'(dmem_rdata >> {addr_reg[1:0], 3'b000});
  assign half_sel = 16'(dmem_rdata >> {addr_reg[1], 4'b0000});

  always_comb begin
    case (size_reg)
      2'b00:   load_ext = unsigned_reg ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = unsigned_reg ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      be_reg       <= '0;
      size_reg     <= '0;
      writereg_reg <= '0;
      unsigned_reg <= 1'b0;
      we_reg       <= 1'b0;
      memtoreg_reg <= 1'b0;
      regwrite_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (state_reg == IDLE && in_mem_op && !in_misalign) begin
        addr_reg     <= inALUResult;
        wdata_reg    <= in_wdata;
        rdata_reg    <= '0;
        be_reg       <= in_be;
        size_reg     <= inMemSize;
        writereg_reg <= inWriteReg;
        unsigned_reg <= inMemUnsigned;
        we_reg       <= inMemWrite;
        memtoreg_reg <= inMemToReg;
        regwrite_reg <= inRegWrite;
        err_reg      <= 1'b0;
      end
      if (state_reg == BUSY) begin
        if (dmem_ack && !we_reg) rdata_reg <= load_ext;
        if (!dmem_ack && count_reg == TIMEOUT_LAST) err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    stall        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = we_reg;
    dmem_addr    = {addr_reg[31:2], 2'b00};
    dmem_be      = be_reg;
    dmem_wdata   = wdata_reg;
    outValid     = 1'b0;
    outALUResult = inALUResult;
    outReadData  = '0;
    outWriteReg  = inWriteReg;
    outMemToReg  = inMemToReg;
    outRegWrite  = 1'b0;
    outMisalign  = 1'b0;
    outMemErr    = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (in_mem_op && in_misalign) begin
          outValid    = 1'b1;
          outMisalign = 1'b1;
        end else if (in_mem_op) begin
          stall      = 1'b1;
          state_next = BUSY;
        end else begin
          outValid    = inValid;
          outRegWrite = inRegWrite & inValid;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack || count_reg == TIMEOUT_LAST) state_next = DONE;
        else count_next = count_reg + 16'd1;
      end
      DONE: begin
        outValid     = 1'b1;
        outALUResult = addr_reg;
        outReadData  = err_reg ? 32'd0 : rdata_reg;
        outWriteReg  = writereg_reg;
        outMemToReg  = memtoreg_reg;
        outRegWrite  = regwrite_reg & ~err_reg;
        outMemErr    = err_reg;
        state_next   = IDLE;
        count_next   = '0;
      end
      default: state_next = IDLE;
    endcase
    // Reset silences every output immediately, even before the state register clears
    if (!rst) begin
      stall        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = '0;
      dmem_be      = '0;
      dmem_wdata   = '0;
      outValid     = 1'b0;
      outALUResult = '0;
      outReadData  = '0;
      outWriteReg  = '0;
      outMemToReg  = 1'b0;
      outRegWrite  = 1'b0;
      outMisalign  = 1'b0;
      outMemErr    = 1'b0;
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM register and the MEM/WB register, and drives that register's inputs directly.
- Performs loads and stores to data memory over a req/ack handshake.
- Generates byte enables and store-data replication, and sign/zero-extends load data.
- Stalls upstream while an access is outstanding and flags misalignment and ack timeout.

Parameters:
- ACK_TIMEOUT, 255: maximum BUSY cycles without dmem_ack before the access is aborted. Legal range 1 to 65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- inValid  in  1  EX/MEM holds a valid instruction
- inALUResult  in  32  memory address, or ALU result for non-memory ops
- inWriteData  in  32  store data (rs2)
- inWriteReg  in  5  destination register
- inMemRead  in  1  load
- inMemWrite  in  1  store
- inMemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- inMemUnsigned  in  1  zero-extend load
- inMemToReg  in  1  passthrough
- inRegWrite  in  1  passthrough
- stall  out  1  upstream must hold EX/MEM and PC
- dmem_req  out  1  memory request
- dmem_we  out  1  write
- dmem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  replicated store data
- dmem_ack  in  1  request accepted and completed this cycle
- dmem_rdata  in  32  read word, valid with dmem_ack
- outValid  out  1  valid result for MEM/WB
- outALUResult  out  32  to MEM/WB
- outReadData  out  32  extended load data, 0 for non-loads
- outWriteReg  out  5  to MEM/WB
- outMemToReg  out  1  to MEM/WB
- outRegWrite  out  1  to MEM/WB, gated
- outMisalign  out  1  misaligned access
- outMemErr  out  1  ack timeout

Behaviour:
- Reset:
  - rst is sampled on posedge clk. When low: state=IDLE, timeout counter=0, all latched fields=0.
  - While rst is low, every output is forced to 0, including stall and dmem_req.
  - Reset mid-BUSY abandons the access. dmem_req is low from the next edge onward. No outValid is produced for the abandoned op.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op, or inValid=0: outputs are combinational passthrough. outValid=inValid, outReadData=0, outRegWrite=inRegWrite&inValid, stall=0.
  - Misaligned memory op (half with addr[0]=1; word with addr[1:0]!=0): no request is issued. Same cycle: outValid=1, outMisalign=1, outRegWrite=0, stall=0. State stays IDLE.
  - Aligned memory op:
    - Same cycle: stall=1 and outValid=0.
    - At the edge: latch address, size, unsigned, wdata, WriteReg, MemToReg, RegWrite and the we flag; go to BUSY.
    - If inMemRead and inMemWrite are both 1, the op is a store.
- BUSY:
  - dmem_req=1 and stall=1. dmem_we, dmem_addr, dmem_be and dmem_wdata come from the latched fields and are stable for the whole of BUSY.
  - On dmem_ack: capture the extended load data and go to DONE.
  - Without ack: the counter increments. When the counter reaches ACK_TIMEOUT-1 with no ack, the next state is DONE with the error flag set.
- DONE:
  - stall=0 and dmem_req=0. outValid=1, with outputs taken from the latched fields.
  - outMemErr=1 if timed out; in that case outRegWrite=0 and outReadData=0.
  - Next state is IDLE and the counter clears. The next instruction is presented in the following cycle.
- Timing: the best case with ack in the first BUSY cycle is 2 stall cycles. The op is presented at T, BUSY at T+1, DONE/outValid at T+2.
- Byte enables, little-endian:
  - byte: be = 1<<addr[1:0], wdata = {4{wd[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
  - word: be = 1111, wdata = wd
  - For loads, dmem_be is set the same way.
- Load extraction:
  - byte: rdata[8*addr[1:0] +: 8]
  - half: rdata[16*addr[1] +: 16]
  - The selected field is sign-extended unless the unsigned flag is set.
  - For stores, outReadData=0.
- An ack seen outside BUSY is ignored.
- dmem_req is never asserted in IDLE or DONE.
- Faults are flagged only; squashing or trapping on them is handled elsewhere.

Test Plan:
- Non-memory op: inALUResult=0x1234, RegWrite=1, WriteReg=5 → same cycle outValid=1, outALUResult=0x1234, outRegWrite=1, stall=0, dmem_req never asserted.
- lw at 0x100 with ack on the first BUSY cycle and rdata=0xDEADBEEF → stall high 2 cycles; dmem_addr=0x100, be=1111; outReadData=0xDEADBEEF at T+2.
- lb at 0x103 with rdata=0x80FF0000 → be=1000, outReadData=0xFFFFFF80. Repeat as lbu → 0x00000080. lh at 0x102 → 0xFFFF80FF.
- sb at 0x101 with wd=0x000000AB → dmem_we=1, be=0010, wdata=0xABABABAB, outReadData=0. Ack delayed 3 cycles → stall for 4 cycles, fields stable throughout.
- lw at 0x102 → same cycle outMisalign=1, outRegWrite=0, no dmem_req. With ACK_TIMEOUT=4 and no ack → exactly 4 BUSY cycles, then outMemErr=1, outRegWrite=0, back to IDLE.
- rst low during the second BUSY cycle → dmem_req=0 and all outputs 0 from the next edge. After release, a new lw completes normally.
